aes_blok_paketleyici: RTL and testbench

- Upstream feeder for the AES encryption engine.
- Accepts a 32-bit word stream over a valid/ready handshake and assembles the words into 128-bit plaintext blocks.
- Short final blocks are zero-padded.
- Completed blocks are buffered in a small block FIFO and presented to the engine's `blok`/`g_gecerli` inputs. The engine's `hazir` output is the consume/ready signal.

---
 rtl/aes_blok_paketleyici.sv | 135 +++++++++++++
 tb/tb_aes_blok_paketleyici.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_blok_paketleyici.sv
// AES plaintext block packer: gathers 32-bit words into 128-bit blocks,
// zero-pads short final blocks, and queues finished blocks for the engine.
module aes_blok_paketleyici #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              s_veri,
  input  logic                     s_gecerli,
  input  logic                     s_son,
  output logic                     s_hazir,
  output logic [127:0]             blok,
  output logic                     g_gecerli,
  input  logic                     hazir,
  output logic                     blok_son,
  output logic                     blok_dolgulu,
  output logic [$clog2(DEPTH):0]   doluluk,
  output logic [CNT_W-1:0]         blok_sayac
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [127:0] data;
    logic         son;
    logic         dolgulu;
  } entry_t;

  entry_t         mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic [1:0]     wcnt;
  logic [127:0]   asm_q;
  logic [CNT_W-1:0] sayac_q;

  logic           accept;
  logic           complete;
  logic           push;
  logic           pop;
  logic [127:0]   placed;
  logic [127:0]   merged;
  entry_t         head;
  entry_t         new_entry;

  // Handshakes: input readiness depends only on the registered fill level.
  assign s_hazir   = (count < FULL_CNT);
  assign g_gecerli = (count != '0);
  assign accept    = s_gecerli && s_hazir;
  assign pop       = g_gecerli && hazir;
  assign complete  = (wcnt == 2'd3) || s_son;
  assign push      = accept && complete;

  // Steer the incoming word into its big-endian slot of the block.
  always_comb begin
    placed = '0;
    case (wcnt)
      2'd0:    placed = {s_veri, 96'b0};
      2'd1:    placed = {32'b0, s_veri, 64'b0};
      2'd2:    placed = {64'b0, s_veri, 32'b0};
      default: placed = {96'b0, s_veri};
    endcase
  end

  // The assembly register holds only filled words, so the merge leaves
  // unfilled lower words at zero, which is exactly the padding.
  assign merged            = asm_q | placed;
  assign new_entry.data    = merged;
  assign new_entry.son     = s_son;
  assign new_entry.dolgulu = s_son && (wcnt != 2'd3);

  // Block storage write port.
  // NOTE: the data array has no reset; outputs are masked while the FIFO is
  // empty, so stale contents are never visible and the array can map to RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  // Word assembly, FIFO pointers, fill level and delivered-block counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt    <= 2'd0;
      asm_q   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      sayac_q <= '0;
    end else begin
      if (accept) begin
        if (complete) begin
          wcnt  <= 2'd0;
          asm_q <= '0;
        end else begin
          wcnt  <= wcnt + 2'd1;
          asm_q <= merged;
        end
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        sayac_q <= sayac_q + CNT_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Head-of-queue presentation, forced to zero when nothing is queued.
  always_comb begin
    head         = mem[rd_ptr];
    blok         = '0;
    blok_son     = 1'b0;
    blok_dolgulu = 1'b0;
    if (g_gecerli) begin
      blok         = head.data;
      blok_son     = head.son;
      blok_dolgulu = head.dolgulu;
    end
  end

  assign doluluk    = count;
  assign blok_sayac = sayac_q;

endmodule

// File: tb/tb_aes_blok_paketleyici.sv
// Directed bench for the AES block packer; small DEPTH and CNT_W so that
// full-FIFO stalls and counter wrap are reachable in a few cycles.
module tb_aes_blok_paketleyici;

  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [31:0]            s_veri = '0;
  logic                   s_gecerli = 1'b0;
  logic                   s_son = 1'b0;
  logic                   s_hazir;
  logic [127:0]           blok;
  logic                   g_gecerli;
  logic                   hazir = 1'b1;
  logic                   blok_son;
  logic                   blok_dolgulu;
  logic [$clog2(DEPTH):0] doluluk;
  logic [CNT_W-1:0]       blok_sayac;

  int checks = 0;
  int failures = 0;

  aes_blok_paketleyici #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_veri       (s_veri),
    .s_gecerli    (s_gecerli),
    .s_son        (s_son),
    .s_hazir      (s_hazir),
    .blok         (blok),
    .g_gecerli    (g_gecerli),
    .hazir        (hazir),
    .blok_son     (blok_son),
    .blok_dolgulu (blok_dolgulu),
    .doluluk      (doluluk),
    .blok_sayac   (blok_sayac)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Starts and ends on a falling edge; s_hazir is stable there and holds
  // through the following rising edge, so it tells whether the word lands.
  task automatic send_word(input logic [31:0] w, input logic last);
    bit done = 1'b0;
    s_veri    = w;
    s_gecerli = 1'b1;
    s_son     = last;
    for (int i = 0; i < 60 && !done; i++) begin
      done = s_hazir;
      @(negedge clk);
    end
    s_gecerli = 1'b0;
    s_son     = 1'b0;
    s_veri    = '0;
    if (!done) check("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic send_block(input logic [127:0] b);
    send_word(b[127:96], 1'b0);
    send_word(b[95:64],  1'b0);
    send_word(b[63:32],  1'b0);
    send_word(b[31:0],   1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  logic [127:0] got_q[$];
  logic [127:0] exp_blk [3];

  initial begin
    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check("rst_g_gecerli", g_gecerli, 1'b0);
    check("rst_blok", blok, '0);
    check("rst_blok_son", blok_son, 1'b0);
    check("rst_blok_dolgulu", blok_dolgulu, 1'b0);
    check("rst_s_hazir", s_hazir, 1'b1);
    check("rst_doluluk", doluluk, '0);
    check("rst_blok_sayac", blok_sayac, '0);
    rst = 1'b1;
    @(negedge clk);

    // ---------------- 1: full block closed by s_son on word 4 ----------------
    hazir = 1'b1;
    send_word(32'h00112233, 1'b0);
    send_word(32'h44556677, 1'b0);
    send_word(32'h8899AABB, 1'b0);
    check("t1_no_early_valid", g_gecerli, 1'b0);
    send_word(32'hCCDDEEFF, 1'b1);
    check("t1_g_gecerli", g_gecerli, 1'b1);
    check("t1_blok", blok, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    check("t1_blok_son", blok_son, 1'b1);
    check("t1_blok_dolgulu", blok_dolgulu, 1'b0);
    @(negedge clk);
    check("t1_popped", g_gecerli, 1'b0);
    check("t1_blok_sayac", blok_sayac, 4'd1);
    check("t1_doluluk", doluluk, '0);

    // ---------------- 2: short block padded, stray s_son ignored ----------------
    send_word(32'hDEADBEEF, 1'b0);
    s_son = 1'b1;            // without s_gecerli this must not close the block
    @(negedge clk);
    s_son = 1'b0;
    check("t2_lone_son_ignored", g_gecerli, 1'b0);
    send_word(32'h01020304, 1'b1);
    check("t2_blok", blok, 128'hDEADBEEF_01020304_00000000_00000000);
    check("t2_blok_son", blok_son, 1'b1);
    check("t2_blok_dolgulu", blok_dolgulu, 1'b1);
    @(negedge clk);
    send_block(128'hA0A0A0A0_A1A1A1A1_A2A2A2A2_A3A3A3A3);
    check("t2_fresh_blok", blok, 128'hA0A0A0A0_A1A1A1A1_A2A2A2A2_A3A3A3A3);
    check("t2_fresh_son", blok_son, 1'b0);
    check("t2_fresh_dolgulu", blok_dolgulu, 1'b0);
    @(negedge clk);
    check("t2_blok_sayac", blok_sayac, 4'd3);

    // ---------------- 3: engine stalled, FIFO fills, then drains in order ----------------
    do_reset();
    hazir = 1'b0;
    exp_blk[0] = 128'h10000001_10000002_10000003_10000004;
    exp_blk[1] = 128'h20000001_20000002_20000003_20000004;
    exp_blk[2] = 128'h30000001_30000002_30000003_30000004;
    send_block(exp_blk[0]);
    send_block(exp_blk[1]);
    check("t3_full_s_hazir", s_hazir, 1'b0);
    check("t3_full_doluluk", doluluk, 3'(DEPTH));
    got_q.delete();
    fork
      begin
        send_block(exp_blk[2]);
      end
      begin
        repeat (3) @(negedge clk);
        check("t3_stall_doluluk", doluluk, 3'(DEPTH));
        check("t3_stall_s_hazir", s_hazir, 1'b0);
        check("t3_stall_head", blok, exp_blk[0]);
        hazir = 1'b1;
        for (int i = 0; i < 100 && got_q.size() < 3; i++) begin
          if (g_gecerli) got_q.push_back(blok);
          @(negedge clk);
        end
      end
    join
    check("t3_count", 32'(got_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      check($sformatf("t3_order_%0d", i), got_q[i], exp_blk[i]);
    end
    check("t3_drained", g_gecerli, 1'b0);
    check("t3_doluluk", doluluk, '0);
    check("t3_blok_sayac", blok_sayac, 4'd3);

    // ---------------- 4: push and pop on the same edge ----------------
    hazir = 1'b0;
    send_block(128'h41414141_42424242_43434343_44444444);
    send_word(32'h55555551, 1'b0);
    send_word(32'h55555552, 1'b0);
    send_word(32'h55555553, 1'b0);
    check("t4_pre_doluluk", doluluk, 3'd1);
    s_veri = 32'h55555554; s_gecerli = 1'b1; s_son = 1'b0;
    hazir = 1'b1;
    check("t4_pre_s_hazir", s_hazir, 1'b1);
    @(negedge clk);
    s_gecerli = 1'b0; s_veri = '0;
    check("t4_doluluk", doluluk, 3'd1);
    check("t4_g_gecerli", g_gecerli, 1'b1);
    check("t4_blok", blok, 128'h55555551_55555552_55555553_55555554);
    @(negedge clk);
    check("t4_drained", doluluk, '0);
    check("t4_blok_sayac", blok_sayac, 4'd5);

    // ---------------- 5: asynchronous reset mid-cycle ----------------
    hazir = 1'b0;
    send_block(128'h66666661_66666662_66666663_66666664);
    send_word(32'h77777771, 1'b0);
    send_word(32'h77777772, 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("t5_g_gecerli", g_gecerli, 1'b0);
    check("t5_blok", blok, '0);
    check("t5_doluluk", doluluk, '0);
    check("t5_blok_sayac", blok_sayac, '0);
    check("t5_s_hazir", s_hazir, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    hazir = 1'b1;
    @(negedge clk);
    send_block(128'h88888881_88888882_88888883_88888884);
    check("t5_new_blok", blok, 128'h88888881_88888882_88888883_88888884);
    @(negedge clk);

    // ---------------- 6: delivered-block counter wrap ----------------
    do_reset();
    hazir = 1'b1;
    for (int i = 0; i < 15; i++) begin
      send_word(32'hC0DE0000 + i, 1'b1);
      if (i == 7) begin
        check("t6_single_blok", blok, {32'hC0DE0007, 96'b0});
        check("t6_single_dolgulu", blok_dolgulu, 1'b1);
      end
    end
    @(negedge clk);
    check("t6_sayac_15", blok_sayac, 4'hF);
    send_word(32'hC0DE000F, 1'b1);
    send_word(32'hC0DE0010, 1'b1);
    @(negedge clk);
    check("t6_sayac_17", blok_sayac, 4'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end

endmodule
